// File: rtl/rom_dl_pkg.sv
// rtl/rom_dl_pkg.sv - shared types and constants for the ROM download scheduler
package rom_dl_pkg;

  localparam int REGION_CNT = 8;
  localparam int REGION_AW  = 13;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

  // The top three address bits pick one of the eight ROM regions.
  function automatic logic [REGION_CNT-1:0] region_cs(input logic [15:0] addr);
    logic [REGION_CNT-1:0] cs;
    cs = '0;
    cs[addr[15:13]] = 1'b1;
    return cs;
  endfunction

endpackage

// File: rtl/rom_dl_sched_if.sv
// rtl/rom_dl_sched_if.sv - download stream and target write handshake bundle
interface rom_dl_sched_if;

  logic        DL_ACT;
  logic        ROMEN;
  logic [15:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        WR_REQ;
  logic        WR_ACK;
  logic [12:0] WR_AD;
  logic [7:0]  WR_DT;
  logic [7:0]  WR_CS;

  modport master (
    output DL_ACT, ROMEN, ROMAD, ROMDT, WR_ACK,
    input  WR_REQ, WR_AD, WR_DT, WR_CS
  );

  modport slave (
    input  DL_ACT, ROMEN, ROMAD, ROMDT, WR_ACK,
    output WR_REQ, WR_AD, WR_DT, WR_CS
  );

endinterface

// File: rtl/rom_dl_fifo.sv
// rtl/rom_dl_fifo.sv - synchronous write-buffer FIFO with first-word output
module rom_dl_fifo
  import rom_dl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  dl_entry_t wdata,
  output dl_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  dl_entry_t     mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign rdata = mem_q[rptr_q];

  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/rom_dl_sched.sv
// rtl/rom_dl_sched.sv - download write scheduler: FSM, region decode, DONE/OVF
// Optional CKSUM output and accumulator when ROM_DL_SCHED_CKSUM_EN is defined.
module rom_dl_sched
  import rom_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          ROMCL,
  input  logic          RESET,
  rom_dl_sched_if.slave dl,
  output logic          BUSY,
  output logic          DONE,
  output logic          OVF
`ifdef ROM_DL_SCHED_CKSUM_EN
  ,
  output logic [15:0]   CKSUM
`endif
);

  state_e                  state_q, state_d;
  logic [REGION_AW-1:0]    ad_q, ad_d;
  logic [7:0]              dt_q, dt_d;
  logic [REGION_CNT-1:0]   cs_q, cs_d;
  logic                    ovf_q, ovf_d;
  logic                    act_q, act_d;
  logic                    fell_q, fell_d;
  logic                    fifo_pop, fifo_full, fifo_empty;
  dl_entry_t               fifo_wdata, fifo_rdata;
  logic                    dl_rise, dl_fall, ack, done;

  assign fifo_wdata = '{addr: dl.ROMAD, data: dl.ROMDT};

  rom_dl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (ROMCL),
    .rst   (RESET),
    .push  (dl.ROMEN),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    ad_d     = ad_q;
    dt_d     = dt_q;
    cs_d     = cs_q;
    fifo_pop = 1'b0;
    ack      = (state_q == REQ) && dl.WR_ACK;
    dl_rise  = dl.DL_ACT && !act_q;
    dl_fall  = !dl.DL_ACT && act_q;
    done     = fell_q && fifo_empty && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (dl.WR_ACK) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      ad_d = fifo_rdata.addr[REGION_AW-1:0];
      dt_d = fifo_rdata.data;
      cs_d = region_cs(fifo_rdata.addr);
    end

    act_d  = dl.DL_ACT;
    ovf_d  = (ovf_q && !dl_rise) || (dl.ROMEN && fifo_full && !fifo_pop);
    // The fall is remembered until the buffer drains, so DONE fires once per download.
    fell_d = !dl_rise && ((fell_q && !done) || dl_fall);
  end

  always_ff @(posedge ROMCL) begin
    if (RESET) begin
      state_q <= IDLE;
      ad_q    <= '0;
      dt_q    <= '0;
      cs_q    <= '0;
      ovf_q   <= 1'b0;
      act_q   <= 1'b0;
      fell_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ad_q    <= ad_d;
      dt_q    <= dt_d;
      cs_q    <= cs_d;
      ovf_q   <= ovf_d;
      act_q   <= act_d;
      fell_q  <= fell_d;
    end
  end

  assign dl.WR_REQ = (state_q == REQ);
  assign dl.WR_AD  = ad_q;
  assign dl.WR_DT  = dt_q;
  assign dl.WR_CS  = cs_q;
  assign BUSY      = !fifo_empty || (state_q == REQ);
  assign DONE      = done;
  assign OVF       = ovf_q;

`ifdef ROM_DL_SCHED_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (dl_rise) begin
      cksum_d = '0;
    end else if (ack) begin
      cksum_d = cksum_q + {8'h00, dt_q};
    end
  end

  always_ff @(posedge ROMCL) begin
    if (RESET) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign CKSUM = cksum_q;
`endif

endmodule

// File: tb/tb_rom_dl_sched.sv
// tb/tb_rom_dl_sched.sv - scoreboard bench for rom_dl_sched (honours ROM_DL_SCHED_CKSUM_EN)
module tb_rom_dl_sched;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy, done, ovf;
`ifdef ROM_DL_SCHED_CKSUM_EN
  logic [15:0] cksum;
`endif

  always #5 clk = ~clk;

  rom_dl_sched_if intf ();

  rom_dl_sched #(.FIFO_DEPTH(DEPTH)) dut (
    .ROMCL (clk),
    .RESET (rst),
    .dl    (intf),
    .BUSY  (busy),
    .DONE  (done),
    .OVF   (ovf)
`ifdef ROM_DL_SCHED_CKSUM_EN
    ,
    .CKSUM (cksum)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;
  int acks        = 0;
  bit mon_en      = 1'b0;

  // Reference model: bytes waiting in the buffer, the one being presented, and the
  // scoreboard of accepted writes in delivery order.
  logic [23:0] mq[$];
  logic [23:0] exp_q[$];
  logic [23:0] cur;
  bit          pres, m_ovf, m_fell, m_prev_act;
  logic [15:0] m_ck;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin
    bit done_now, complete, pop, acc, rise, fall;
    if (rst) begin
      mq.delete();
      exp_q.delete();
      pres       = 1'b0;
      m_ovf      = 1'b0;
      m_fell     = 1'b0;
      m_prev_act = 1'b0;
      m_ck       = '0;
    end else begin
      done_now = m_fell && (mq.size() == 0) && !pres;
      complete = pres && intf.WR_ACK;
      pop      = (mq.size() != 0) && (!pres || intf.WR_ACK);
      acc      = intf.ROMEN && ((mq.size() < DEPTH) || pop);
      rise     = intf.DL_ACT && !m_prev_act;
      fall     = !intf.DL_ACT && m_prev_act;
      if (rise) m_ck = '0;
      else if (complete) m_ck = m_ck + 16'(cur[7:0]);
      if (rise) m_ovf = 1'b0;
      if (intf.ROMEN && !acc) m_ovf = 1'b1;
      if (rise) m_fell = 1'b0;
      else if (fall) m_fell = 1'b1;
      else if (done_now) m_fell = 1'b0;
      if (complete) pres = 1'b0;
      if (pop) begin
        cur  = mq.pop_front();
        pres = 1'b1;
      end
      if (acc) begin
        mq.push_back({intf.ROMAD, intf.ROMDT});
        exp_q.push_back({intf.ROMAD, intf.ROMDT});
      end
      m_prev_act = intf.DL_ACT;
    end
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (mon_en && !rst) begin
      chk("WR_REQ", 32'(intf.WR_REQ), 32'(pres));
      chk("BUSY", 32'(busy), 32'((mq.size() != 0) || pres));
      chk("OVF", 32'(ovf), 32'(m_ovf));
      chk("DONE", 32'(done), 32'(m_fell && (mq.size() == 0) && !pres));
      if (intf.WR_REQ === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: got request ad=%0h dt=%0h, required none", intf.WR_AD, intf.WR_DT);
        end else begin
          e = exp_q[0];
          chk("WR_AD", 32'(intf.WR_AD), 32'(e[20:8]));
          chk("WR_DT", 32'(intf.WR_DT), 32'(e[7:0]));
          chk("WR_CS", 32'(intf.WR_CS), 32'(1) << e[23:21]);
          if (intf.WR_ACK === 1'b1) begin
            void'(exp_q.pop_front());
            acks++;
          end
        end
      end
`ifdef ROM_DL_SCHED_CKSUM_EN
      if (done === 1'b1) chk("CKSUM", 32'(cksum), 32'(m_ck));
`endif
    end
  end

  task automatic step(input bit en, input logic [15:0] ad, input logic [7:0] dt, input bit ack);
    intf.ROMEN  = en;
    intf.ROMAD  = ad;
    intf.ROMDT  = dt;
    intf.WR_ACK = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, cnt, first, last, at;
    bit got;
    intf.DL_ACT = 1'b0;
    intf.ROMEN  = 1'b0;
    intf.ROMAD  = '0;
    intf.ROMDT  = '0;
    intf.WR_ACK = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_WR_REQ", 32'(intf.WR_REQ), 32'd0);
    chk("rst_WR_CS", 32'(intf.WR_CS), 32'd0);
    chk("rst_WR_AD", 32'(intf.WR_AD), 32'd0);
    chk("rst_WR_DT", 32'(intf.WR_DT), 32'd0);
    chk("rst_BUSY", 32'(busy), 32'd0);
    chk("rst_DONE", 32'(done), 32'd0);
    chk("rst_OVF", 32'(ovf), 32'd0);
    mon_en = 1'b1;

    // Single write with WR_ACK tied high.
    intf.DL_ACT = 1'b1;
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 16'h4123, 8'hA5, 1'b1);
    chk("single_req_latency", 32'(intf.WR_REQ), 32'd0);
    step(1'b0, '0, '0, 1'b1);
    chk("single_req", 32'(intf.WR_REQ), 32'd1);
    chk("single_cs", 32'(intf.WR_CS), 32'h04);
    chk("single_ad", 32'(intf.WR_AD), 32'h0123);
    chk("single_dt", 32'(intf.WR_DT), 32'hA5);
    step(1'b0, '0, '0, 1'b1);
    chk("single_one_cycle", 32'(intf.WR_REQ), 32'd0);

    // Back-to-back: 16 pushes, expect 16 contiguous request cycles.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 16'($urandom), 8'($urandom), 1'b1);
      if (intf.WR_REQ === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("b2b_count", 32'(cnt), 32'd16);
    chk("b2b_no_bubble", 32'(last - first + 1), 32'd16);
    chk("b2b_ovf", 32'(ovf), 32'd0);

    // Backpressure: 6 pushes against a stalled target; 5 retained, one dropped.
    for (int i = 0; i < 20; i++) step(i < 6, 16'($urandom), 8'($urandom), 1'b0);
    chk("bp_ovf", 32'(ovf), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    a0 = acks;
    repeat (8) step(1'b0, '0, '0, 1'b1);
    chk("bp_delivered", 32'(acks - a0), 32'd5);

    // Reset mid-transfer with three entries buffered.
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 8'($urandom), 1'b0);
    chk("rstmid_req_before", 32'(intf.WR_REQ), 32'd1);
    rst = 1'b1;
    step(1'b0, '0, '0, 1'b0);
    rst = 1'b0;
    chk("rstmid_req", 32'(intf.WR_REQ), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ovf", 32'(ovf), 32'd0);
    a0 = acks;
    repeat (5) step(1'b0, '0, '0, 1'b1);
    chk("rstmid_no_req", 32'(acks - a0), 32'd0);

    // Full FIFO with a push and a pop in the same cycle.
    a0 = acks;
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 8'($urandom), 1'b0);
    chk("full_ovf_before", 32'(ovf), 32'd0);
    step(1'b1, 16'hE0F0, 8'h5A, 1'b1);
    chk("full_pop_ovf", 32'(ovf), 32'd0);
    repeat (8) step(1'b0, '0, '0, 1'b1);
    chk("full_pop_delivered", 32'(acks - a0), 32'd6);

    // Completion: DL_ACT falls with 3 writes pending, acked every other cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 8'($urandom), 1'b0);
    intf.DL_ACT = 1'b0;
    cnt = 0; at = -1;
    for (int c = 0; c < 14; c++) begin
      step(1'b0, '0, '0, (c % 2 == 1) && (c < 6));
      if (done === 1'b1) begin
        cnt++;
        at = c;
      end
    end
    chk("done_count", 32'(cnt), 32'd1);
    chk("done_cycle", 32'(at), 32'd5);

    // Randomized download.
    intf.DL_ACT = 1'b1;
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 16'($urandom), 8'($urandom), ($urandom % 5) < 3);
    intf.DL_ACT = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(1'b0, '0, '0, 1'b1);
      if (done === 1'b1) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL rand_done_timeout: got no DONE in 40 cycles, required one");
    end
    repeat (3) step(1'b0, '0, '0, 1'b1);
    chk("rand_all_delivered", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rom_dl_sched.md
# rom_dl_sched

Download write scheduler between the HPS ioctl download stream and the core's ROM/RAM write ports. It buffers incoming byte writes in a small FIFO and decodes each address into one of eight ROM regions. It presents each write to the target through a request/acknowledge handshake, so targets that can only accept writes on some cycles (shared video/CPU ROM ports) never lose a byte. It also reports download completion and overflow.

## Interface
Parameters:
- FIFO_DEPTH, 4: write-buffer entries; power of two, 2..16.

Ports:
- ROMCL  in  1  download/system clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- DL_ACT  in  1  download active (ioctl_download level).
- ROMEN  in  1  write strobe; one byte per cycle when high.
- ROMAD  in  16  byte address of the write.
- ROMDT  in  8  write data.
- WR_REQ  out  1  write request to the target.
- WR_ACK  in  1  target accepts the presented write.
- WR_AD  out  13  offset within the region (ROMAD[12:0]).
- WR_DT  out  8  data.
- WR_CS  out  8  one-hot region select, ROMAD[15:13] decoded.
- BUSY  out  1  FIFO non-empty or WR_REQ high.
- DONE  out  1  single-cycle pulse at download completion.
- OVF  out  1  sticky: a write was dropped.

## Operation
- Push: ROMEN=1 and FIFO not full pushes {ROMAD,ROMDT}. ROMEN=1 with FIFO full and no pop in the same cycle drops the byte and sets OVF.
- Two-state FSM:
  - IDLE: WR_REQ=0. If the FIFO is non-empty, pop the head into the output registers, decode WR_CS, and go to REQ.
  - REQ: WR_REQ=1 and the outputs are held stable. On WR_ACK=1, the transfer completes. If the FIFO is non-empty, load the next entry and stay in REQ (back-to-back). Otherwise go to IDLE.
- WR_ACK while WR_REQ=0 is ignored.
- Push and pop in the same cycle are legal at any occupancy, including full, and do not overflow.
- DL_ACT rising edge clears OVF. DL_ACT must not rise while BUSY=1; if it does, the pending data is still delivered.
- DONE pulses for one cycle on the first cycle in which DL_ACT has fallen (remembered edge), FIFO is empty and WR_REQ=0. It pulses exactly once per download.
- Region decode is fixed: WR_CS = 1 << ROMAD[15:13].

## Timing
- Reset values: WR_REQ=0, WR_CS=0, WR_AD=0, WR_DT=0, BUSY=0, DONE=0, OVF=0, FIFO empty, FSM IDLE.
- Latency: push at edge n into an empty FIFO with FSM IDLE gives WR_REQ=1 with valid outputs after edge n+1.
- Throughput: one write per cycle while WR_ACK is held high.
- The acknowledge edge is the edge at which WR_REQ=1 and WR_ACK=1. The next entry is visible after that same edge.
- RESET mid-transfer flushes the FIFO and drops WR_REQ after the reset edge. The target must tolerate an abandoned request.

## Configuration
- ROM_DL_SCHED_CKSUM_EN defined: adds output CKSUM[15:0].
  - CKSUM is the modulo-2^16 sum of WR_DT over all acknowledged writes.
  - It is cleared on the DL_ACT rising edge and on RESET.
  - It is stable when DONE pulses.
- Macro undefined: no CKSUM port and no accumulator logic.

## Structure
- Shared package rom_dl_pkg:
  - region count constant (8) and region width (13);
  - the FSM state enum {IDLE, REQ};
  - the FIFO entry struct {addr[15:0], data[7:0]}.
- One sub-module, rom_dl_fifo: synchronous FIFO, FIFO_DEPTH entries, with push/pop/full/empty and first-word output. The scheduler owns the FSM, region decode, DONE/OVF and the checksum.

## Test plan
- Single write: ROMAD=16'h4123, ROMDT=8'hA5, WR_ACK tied high. Expect one cycle of WR_REQ with WR_CS=8'h04, WR_AD=13'h0123, WR_DT=8'hA5, beginning the cycle after the push.
- Back-to-back: 16 consecutive pushes with WR_ACK=1. Expect 16 consecutive acknowledged writes in order, OVF=0, and no bubble after the first.
- Backpressure: WR_ACK=0 for 20 cycles while pushing 6 bytes with FIFO_DEPTH=4. Expect 5 bytes retained (4 in the FIFO plus 1 presented), OVF=1, and the outputs held stable throughout.
- Completion: drop DL_ACT with 3 writes pending, then ack one per 2 cycles. Expect DONE for exactly one cycle after the last ack. With ROM_DL_SCHED_CKSUM_EN defined, CKSUM equals the byte sum.
- Reset mid-transfer: assert RESET while WR_REQ=1 with the FIFO at 3 entries. Expect WR_REQ=0, BUSY=0 and OVF=0 after the reset edge, and no further requests.
- Full plus simultaneous pop: FIFO full, ROMEN=1 and WR_ACK=1 in the same cycle. Expect the byte accepted and OVF unchanged.
